// File: rtl/display_sequencer_if.sv
// Handshake/display bus between a controller and the display sequencer.
interface display_sequencer_if;
  logic        load;
  logic [15:0] valor;
  logic        busy;
  logic        blank;
  logic [4:0]  code0;
  logic [4:0]  code1;
  logic [4:0]  code2;
  logic [4:0]  code3;
  logic [1:0]  db_estado;

  // Controller side: drives requests and data, observes digit codes.
  modport master (
    output load, valor, busy, blank,
    input  code0, code1, code2, code3, db_estado
  );

  // Sequencer side.
  modport slave (
    input  load, valor, busy, blank,
    output code0, code1, code2, code3, db_estado
  );
endinterface

// File: rtl/display_sequencer.sv
// Four-digit 7-segment display sequencer: shows a loaded hex value,
// a chasing spinner while busy, or dark digits when blank/no data.
//
// state | meaning
// IDLE  | all digits dark (no valid data, or blank forced)
// SHOW  | digits show the loaded 16-bit value as hex
// SPIN  | digits show a chasing single-segment animation
module display_sequencer #(
  parameter int TICK_DIV = 5000000
) (
  input logic                clock,
  input logic                reset,
  display_sequencer_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    SPIN = 2'd2
  } state_t;

  state_t        r_state, w_state_nx;
  logic [15:0]   r_val, w_val_nx;
  logic          r_valid, w_valid_nx;
  logic [2:0]    r_phase, w_phase_nx;
  logic [TW-1:0] r_tick, w_tick_nx;

  // Segment code for a spinner digit: outer segment (phase + offset) mod 6.
  function automatic logic [4:0] spin_code(input logic [2:0] ph, input logic [2:0] ofs);
    logic [3:0] s;
    s = {1'b0, ph} + {1'b0, ofs};
    if (s >= 4'd6) s = s - 4'd6;
    return {2'b10, s[2:0]};
  endfunction

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_val   <= 16'h0000;
      r_valid <= 1'b0;
      r_phase <= 3'd0;
      r_tick  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_val   <= w_val_nx;
      r_valid <= w_valid_nx;
      r_phase <= w_phase_nx;
      r_tick  <= w_tick_nx;
    end
  end

  // Next state (blank > busy > load) plus value capture and spinner timing.
  always_comb begin
    w_val_nx   = r_val;
    w_valid_nx = r_valid;
    w_phase_nx = r_phase;
    w_tick_nx  = r_tick;
    w_state_nx = IDLE;

    if (bus.load) begin
      w_val_nx   = bus.valor;
      w_valid_nx = 1'b1;
    end

    if (!bus.blank) begin
      if (bus.busy)        w_state_nx = SPIN;
      else if (w_valid_nx) w_state_nx = SHOW;
    end

    // Unused encoding goes straight back to IDLE.
    if (r_state != IDLE && r_state != SHOW && r_state != SPIN) w_state_nx = IDLE;

    // Fresh entry restarts the animation; staying in SPIN advances it.
    if (w_state_nx == SPIN) begin
      if (r_state != SPIN) begin
        w_tick_nx  = '0;
        w_phase_nx = 3'd0;
      end else if (r_tick == TICK_LAST) begin
        w_tick_nx  = '0;
        w_phase_nx = (r_phase >= 3'd5) ? 3'd0 : r_phase + 3'd1;
      end else begin
        w_tick_nx  = r_tick + 1'b1;
      end
    end
  end

  // Moore output decode from registered state only.
  always_comb begin
    bus.code0     = 5'h1F;
    bus.code1     = 5'h1F;
    bus.code2     = 5'h1F;
    bus.code3     = 5'h1F;
    bus.db_estado = 2'd0;
    case (r_state)
      SHOW: begin
        bus.code0     = {1'b0, r_val[3:0]};
        bus.code1     = {1'b0, r_val[7:4]};
        bus.code2     = {1'b0, r_val[11:8]};
        bus.code3     = {1'b0, r_val[15:12]};
        bus.db_estado = 2'd1;
      end
      SPIN: begin
        bus.code0     = spin_code(r_phase, 3'd0);
        bus.code1     = spin_code(r_phase, 3'd1);
        bus.code2     = spin_code(r_phase, 3'd2);
        bus.code3     = spin_code(r_phase, 3'd3);
        bus.db_estado = 2'd2;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_display_sequencer.sv
// Directed bench for display_sequencer with a cycle-level reference model.
module tb_display_sequencer;
  localparam int TD = 4;

  logic clock = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;

  display_sequencer_if bus ();

  display_sequencer #(.TICK_DIV(TD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Reference model: mode, stored value and number of edges spent in SPIN.
  int          m_mode;   // 0 dark, 1 show, 2 spin
  logic [15:0] m_val;
  bit          m_valid;
  int          m_cyc;

  always @(posedge clock) begin
    int nm;
    if (reset) begin
      m_mode = 0; m_val = 16'h0; m_valid = 0; m_cyc = 0;
    end else begin
      if (bus.load) begin m_val = bus.valor; m_valid = 1; end
      nm = bus.blank ? 0 : (bus.busy ? 2 : (m_valid ? 1 : 0));
      if (nm == 2) m_cyc = (m_mode == 2) ? m_cyc + 1 : 0;
      m_mode = nm;
    end
  end

  function automatic logic [4:0] exp_code(int i);
    int ph;
    ph = (m_cyc / TD) % 6;
    case (m_mode)
      1:       return {1'b0, m_val[4*i +: 4]};
      2:       return 5'(16 + (ph + i) % 6);
      default: return 5'h1F;
    endcase
  endfunction

  function automatic logic [4:0] act_code(int i);
    case (i)
      0:       return bus.code0;
      1:       return bus.code1;
      2:       return bus.code2;
      default: return bus.code3;
    endcase
  endfunction

  // Continuous comparison of every output against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      n_assert++;
      if (bus.db_estado !== 2'(m_mode)) begin
        n_fail++;
        $display("FAIL model db_estado t=%0t got %0d want %0d", $time, bus.db_estado, m_mode);
      end
      for (int i = 0; i < 4; i++) begin
        n_assert++;
        if (act_code(i) !== exp_code(i)) begin
          n_fail++;
          $display("FAIL model code%0d t=%0t got %h want %h", i, $time, act_code(i), exp_code(i));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string name, logic [1:0] db, logic [4:0] c3, logic [4:0] c2,
                     logic [4:0] c1, logic [4:0] c0);
    n_assert++;
    if ({bus.db_estado, bus.code3, bus.code2, bus.code1, bus.code0} !== {db, c3, c2, c1, c0}) begin
      n_fail++;
      $display("FAIL %s got db=%0d codes=%h %h %h %h want db=%0d codes=%h %h %h %h", name,
               bus.db_estado, bus.code3, bus.code2, bus.code1, bus.code0, db, c3, c2, c1, c0);
    end
  endtask

  initial begin
    reset = 1'b1; bus.load = 1'b1; bus.valor = 16'hFFFF; bus.busy = 1'b0; bus.blank = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset", 2'd0, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
    reset = 1'b0; bus.load = 1'b0;
    tick();
    chk("after_reset_dark", 2'd0, 5'h1F, 5'h1F, 5'h1F, 5'h1F);

    bus.load = 1'b1; bus.valor = 16'h3A5C;
    tick();
    bus.load = 1'b0;
    chk("load_show", 2'd1, 5'h03, 5'h0A, 5'h05, 5'h0C);
    tick();
    chk("load_hold", 2'd1, 5'h03, 5'h0A, 5'h05, 5'h0C);

    bus.busy = 1'b1;
    tick();
    chk("spin_enter", 2'd2, 5'h13, 5'h12, 5'h11, 5'h10);
    repeat (4) tick();
    chk("spin_phase1", 2'd2, 5'h14, 5'h13, 5'h12, 5'h11);
    repeat (20) tick();
    chk("spin_phase_wrap", 2'd2, 5'h13, 5'h12, 5'h11, 5'h10);
    bus.busy = 1'b0;
    tick();
    chk("spin_exit_show", 2'd1, 5'h03, 5'h0A, 5'h05, 5'h0C);

    bus.busy = 1'b1;
    tick();
    repeat (2) tick();
    bus.load = 1'b1; bus.valor = 16'h1234;
    tick();
    bus.load = 1'b0;
    chk("spin_load_phase0", 2'd2, 5'h13, 5'h12, 5'h11, 5'h10);
    tick();
    chk("spin_load_phase1", 2'd2, 5'h14, 5'h13, 5'h12, 5'h11);
    bus.busy = 1'b0;
    tick();
    chk("spin_load_show", 2'd1, 5'h01, 5'h02, 5'h03, 5'h04);

    bus.blank = 1'b1; bus.busy = 1'b1; bus.load = 1'b1; bus.valor = 16'hBEEF;
    tick();
    bus.load = 1'b0;
    chk("prio_blank", 2'd0, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
    bus.blank = 1'b0;
    tick();
    chk("prio_busy", 2'd2, 5'h13, 5'h12, 5'h11, 5'h10);
    bus.busy = 1'b0;
    tick();
    chk("prio_show", 2'd1, 5'h0B, 5'h0E, 5'h0E, 5'h0F);

    bus.blank = 1'b1;
    tick();
    bus.blank = 1'b0;
    tick();
    chk("blank_retain", 2'd1, 5'h0B, 5'h0E, 5'h0E, 5'h0F);

    reset = 1'b1;
    tick();
    reset = 1'b0; bus.busy = 1'b1;
    tick();
    chk("nodata_spin", 2'd2, 5'h13, 5'h12, 5'h11, 5'h10);
    repeat (5) tick();
    chk("nodata_spin_ph1", 2'd2, 5'h14, 5'h13, 5'h12, 5'h11);
    bus.busy = 1'b0;
    tick();
    chk("nodata_idle", 2'd0, 5'h1F, 5'h1F, 5'h1F, 5'h1F);

    bus.busy = 1'b1;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    chk("reset_mid_spin", 2'd0, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
    reset = 1'b0;
    tick();
    chk("spin_after_reset", 2'd2, 5'h13, 5'h12, 5'h11, 5'h10);

    repeat (6) tick();
    bus.blank = 1'b1;
    tick();
    chk("blank_mid_spin", 2'd0, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
    bus.blank = 1'b0;
    tick();
    chk("blank_respin", 2'd2, 5'h13, 5'h12, 5'h11, 5'h10);
    bus.busy = 1'b0;
    tick();
    chk("respin_exit_idle", 2'd0, 5'h1F, 5'h1F, 5'h1F, 5'h1F);

    @(negedge clock);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
